// File: rtl/fnd_scan_decoder_if.sv
// Bus between a multiplexed 4-digit 7-segment scan source and the scan decoder.
//   fnd_com     : digit commons, active-low, bit0 = ones digit
//   fnd_data    : segments, active-low, bit7 = dp, bits6:0 = g..a
//   digit_bcd   : last valid frame as four BCD nibbles, [15:12] = thousands
//   value       : binary equivalent of digit_bcd
//   frame_valid : one-cycle pulse when digit_bcd/value update
//   frame_err   : one-cycle pulse when a completed frame is discarded
//   com_err     : sticky flag, more than one common seen low
interface fnd_scan_decoder_if;
  logic [3:0]  fnd_com;
  logic [7:0]  fnd_data;
  logic [15:0] digit_bcd;
  logic [13:0] value;
  logic        frame_valid;
  logic        frame_err;
  logic        com_err;

  modport master (
    output fnd_com, fnd_data,
    input  digit_bcd, value, frame_valid, frame_err, com_err
  );

  modport slave (
    input  fnd_com, fnd_data,
    output digit_bcd, value, frame_valid, frame_err, com_err
  );
endinterface

// File: rtl/fnd_scan_decoder.sv
// Observes a multiplexed 4-digit 7-segment display drive and reconstructs the
// displayed number. Inputs are synchronized, debounced by a stability counter,
// sampled once per stable period, and collected into a four-digit frame that
// is published (or discarded on error) once every digit has been seen.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : fnd_scan_decoder_if slave (scan inputs, decoded outputs)
module fnd_scan_decoder #(
  parameter int unsigned SETTLE = 4
) (
  input logic               clk,
  input logic               reset,
  fnd_scan_decoder_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCollect, StCommit} state_e;

  localparam logic [7:0] SettleC  = 8'(SETTLE);
  localparam logic [7:0] SettleM1 = 8'(SETTLE - 1);

  // Synchronizer and stability tracking
  logic [11:0] sync1_q, sync2_q, prev_q;
  logic [1:0]  fill_q;
  logic        prev_vld_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        stable, sample;

  logic [3:0]  cur_com;
  logic [6:0]  cur_seg;
  logic [4:0]  dec;
  logic        one_low;

  // Frame collection
  state_e           state_q, state_d;
  logic [3:0]       seen_q, seen_d;
  logic             err_q, err_d;
  logic [3:0][3:0]  slot_q, slot_d;
  logic             com_err_q, com_err_d;
  logic [13:0]      slot_bin;

  // Outputs
  logic [15:0] bcd_q, bcd_d;
  logic [13:0] value_q, value_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;

  // Returns {ok, bcd}; ok = 0 for any pattern that is not a digit 0..9.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h40:   r = {1'b1, 4'd0};
      7'h79:   r = {1'b1, 4'd1};
      7'h24:   r = {1'b1, 4'd2};
      7'h30:   r = {1'b1, 4'd3};
      7'h19:   r = {1'b1, 4'd4};
      7'h12:   r = {1'b1, 4'd5};
      7'h02:   r = {1'b1, 4'd6};
      7'h78:   r = {1'b1, 4'd7};
      7'h00:   r = {1'b1, 4'd8};
      7'h10:   r = {1'b1, 4'd9};
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      fill_q     <= '0;
      prev_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= {bus.fnd_com, bus.fnd_data};
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      // Comparisons only count once the synchronizer holds real input data,
      // so the reset contents can never be mistaken for a stable value.
      fill_q     <= {fill_q[0], 1'b1};
      prev_vld_q <= fill_q[1];
      cnt_q      <= cnt_d;
    end
  end

  assign stable  = prev_vld_q && (sync2_q == prev_q);
  assign sample  = stable && (cnt_q == SettleM1);
  assign cur_com = sync2_q[11:8];
  assign cur_seg = sync2_q[6:0];
  assign dec     = seg_decode(cur_seg);
  assign one_low = $onehot(~cur_com);

  always_comb begin
    cnt_d = '0;
    if (stable) begin
      cnt_d = (cnt_q >= SettleC) ? SettleC : cnt_q + 8'd1;
    end
  end

  // Seen/error restart on the commit cycle; a sample landing on that same
  // cycle therefore belongs to the next frame.
  always_comb begin
    seen_d    = (state_q == StCommit) ? 4'b0000 : seen_q;
    err_d     = (state_q == StCommit) ? 1'b0 : err_q;
    slot_d    = slot_q;
    com_err_d = com_err_q;
    if (sample && (cur_com != 4'hF)) begin
      if (one_low) begin
        for (int i = 0; i < 4; i++) begin
          if (!cur_com[i]) begin
            seen_d[i] = 1'b1;
            if (dec[4]) slot_d[i] = dec[3:0];
          end
        end
        if (!dec[4]) err_d = 1'b1;
      end else begin
        com_err_d = 1'b1;
        err_d     = 1'b1;
      end
    end
  end

  assign slot_bin = 14'(slot_q[3]) * 14'd1000 + 14'(slot_q[2]) * 14'd100
                  + 14'(slot_q[1]) * 14'd10 + 14'(slot_q[0]);

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    value_d = value_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (seen_d != 4'b0000) state_d = StCollect;
      end
      StCollect: begin
        if (seen_d == 4'hF) state_d = StCommit;
      end
      StCommit: begin
        state_d = StIdle;
        if (err_q) begin
          ferr_d = 1'b1;
        end else begin
          bcd_d   = slot_q;
          value_d = slot_bin;
          valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      seen_q    <= '0;
      err_q     <= 1'b0;
      slot_q    <= '0;
      com_err_q <= 1'b0;
      bcd_q     <= '0;
      value_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      seen_q    <= seen_d;
      err_q     <= err_d;
      slot_q    <= slot_d;
      com_err_q <= com_err_d;
      bcd_q     <= bcd_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign bus.digit_bcd   = bcd_q;
  assign bus.value       = value_q;
  assign bus.frame_valid = valid_q;
  assign bus.frame_err   = ferr_q;
  assign bus.com_err     = com_err_q;

endmodule

// File: tb/tb_fnd_scan_decoder.sv
module tb_fnd_scan_decoder;
  localparam int unsigned SETTLE = 4;
  localparam int HOLD = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fnd_scan_decoder_if bus();

  fnd_scan_decoder #(.SETTLE(SETTLE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Pulse monitor, cumulative over the whole run
  int mon_valid = 0, mon_err = 0, mon_both = 0, mon_run = 0, mon_max_run = 0;
  always @(negedge clk) begin
    if (bus.frame_valid === 1'b1) mon_valid++;
    if (bus.frame_err === 1'b1) mon_err++;
    if (bus.frame_valid === 1'b1 && bus.frame_err === 1'b1) mon_both++;
    if (bus.frame_valid === 1'b1 || bus.frame_err === 1'b1) begin
      mon_run++;
      if (mon_run > mon_max_run) mon_max_run = mon_run;
    end else begin
      mon_run = 0;
    end
  end

  // Reference model: frame-level view of what the display showed
  logic [6:0]  pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00,
                            7'h10};
  int          m_slot [4];
  int          m_seen;
  bit          m_err, m_com_err;
  int          exp_valid = 0, exp_err = 0;
  logic [15:0] exp_bcd;
  int          exp_value;

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_slot[i] = 0;
    m_seen = 0; m_err = 0; m_com_err = 0; exp_bcd = 16'h0; exp_value = 0;
  endtask

  task automatic model_sample(input logic [3:0] c, input logic [7:0] d);
    int lows, idx, dig;
    lows = 0; idx = 0; dig = -1;
    for (int i = 0; i < 4; i++) if (c[i] == 1'b0) begin lows++; idx = i; end
    if (lows == 0) return;
    if (lows > 1) begin m_com_err = 1; m_err = 1; return; end
    for (int k = 0; k < 10; k++) if (pat[k] == d[6:0]) dig = k;
    if (dig < 0) m_err = 1;
    else m_slot[idx] = dig;
    m_seen = m_seen | (1 << idx);
    if (m_seen == 15) begin
      if (m_err) exp_err++;
      else begin
        exp_valid++;
        exp_value = m_slot[3] * 1000 + m_slot[2] * 100 + m_slot[1] * 10 + m_slot[0];
        exp_bcd = 16'(m_slot[3] * 4096 + m_slot[2] * 256 + m_slot[1] * 16 + m_slot[0]);
      end
      m_seen = 0; m_err = 0;
    end
  endtask

  // Drive one scan state for n cycles; long holds are one sample for the model.
  task automatic hold(input logic [3:0] c, input logic [7:0] d, input int n);
    #1;
    bus.fnd_com = c;
    bus.fnd_data = d;
    repeat (n) @(posedge clk);
    if (n >= HOLD) model_sample(c, d);
  endtask

  task automatic scan_number(input int d3, input int d2, input int d1, input int d0);
    hold(4'b1110, {1'b1, pat[d0]}, HOLD);
    hold(4'b1101, {1'b1, pat[d1]}, HOLD);
    hold(4'b1011, {1'b1, pat[d2]}, HOLD);
    hold(4'b0111, {1'b1, pat[d3]}, HOLD);
    hold(4'b1111, 8'hFF, 12);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.fnd_com = 4'b0000;
    bus.fnd_data = 8'h00;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.digit_bcd, bus.value, bus.frame_valid, bus.frame_err, bus.com_err} !== 33'h0) begin
      failures++;
      $display("FAIL reset_outputs: got bcd=%h value=%0d fv=%b fe=%b ce=%b, want all 0",
               bus.digit_bcd, bus.value, bus.frame_valid, bus.frame_err, bus.com_err);
    end
    reset = 1'b1;
    // Multi-low com present at release but too briefly for a full stable period
    repeat (2) @(posedge clk);
    hold(4'b1111, 8'hFF, 12);
    @(negedge clk);
    checks++;
    if (bus.com_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_fill: com_err=%b, want 0", bus.com_err);
    end
  endtask

  task automatic test_scan_1234();
    hold(4'b1110, 8'h99, HOLD);
    hold(4'b1101, 8'hB0, HOLD);
    hold(4'b1011, 8'hA4, HOLD);
    hold(4'b0111, 8'hF9, HOLD);
    hold(4'b1111, 8'hFF, 12);
    @(negedge clk);
    checks++;
    if (bus.digit_bcd !== 16'h1234 || bus.value !== 14'd1234) begin
      failures++;
      $display("FAIL scan_1234: bcd=%h value=%0d, want 1234/1234", bus.digit_bcd, bus.value);
    end
    checks++;
    if (mon_valid !== 1 || mon_err !== 0) begin
      failures++;
      $display("FAIL scan_1234_pulses: valid=%0d err=%0d, want 1/0", mon_valid, mon_err);
    end
  endtask

  task automatic test_9999_0000();
    scan_number(9, 9, 9, 9);
    @(negedge clk);
    checks++;
    if (bus.value !== 14'd9999 || bus.digit_bcd !== 16'h9999) begin
      failures++;
      $display("FAIL scan_9999: value=%0d bcd=%h, want 9999", bus.value, bus.digit_bcd);
    end
    scan_number(0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (bus.value !== 14'd0 || bus.digit_bcd !== 16'h0000) begin
      failures++;
      $display("FAIL scan_0000: value=%0d bcd=%h, want 0", bus.value, bus.digit_bcd);
    end
    checks++;
    if (mon_valid !== exp_valid || mon_max_run !== 1) begin
      failures++;
      $display("FAIL pulse_width: valid=%0d maxrun=%0d, want %0d/1", mon_valid, mon_max_run,
               exp_valid);
    end
  endtask

  task automatic test_glitch();
    // Ones digit preceded by a data toggle that never settles
    for (int i = 0; i < 3; i++) hold(4'b1110, (i % 2 == 0) ? 8'h80 : 8'h92, 1);
    hold(4'b1110, {1'b1, pat[7]}, HOLD);
    for (int i = 0; i < 3; i++) hold(4'b1101, (i % 2 == 0) ? 8'h80 : 8'hC0, 1);
    hold(4'b1101, {1'b1, pat[6]}, HOLD);
    hold(4'b1011, {1'b1, pat[5]}, HOLD);
    hold(4'b0111, {1'b1, pat[4]}, HOLD);
    hold(4'b1111, 8'hFF, 12);
    @(negedge clk);
    checks++;
    if (bus.value !== 14'd4567 || mon_valid !== exp_valid || mon_err !== exp_err) begin
      failures++;
      $display("FAIL glitch: value=%0d valid=%0d err=%0d, want 4567 %0d %0d", bus.value,
               mon_valid, mon_err, exp_valid, exp_err);
    end
  endtask

  task automatic test_blank_digit();
    int v0;
    v0 = mon_valid;
    hold(4'b1110, {1'b1, pat[1]}, HOLD);
    hold(4'b1101, {1'b1, pat[2]}, HOLD);
    hold(4'b1011, 8'hFF, HOLD);
    hold(4'b0111, {1'b1, pat[3]}, HOLD);
    hold(4'b1111, 8'hFF, 12);
    @(negedge clk);
    checks++;
    if (mon_err !== exp_err || exp_err !== 1 || mon_valid !== v0) begin
      failures++;
      $display("FAIL blank_digit_err: err=%0d valid=%0d, want 1 %0d", mon_err, mon_valid, v0);
    end
    checks++;
    if (bus.value !== 14'd4567 || bus.digit_bcd !== 16'h4567) begin
      failures++;
      $display("FAIL blank_digit_hold: value=%0d bcd=%h, want 4567", bus.value, bus.digit_bcd);
    end
    scan_number(8, 0, 2, 1);
    @(negedge clk);
    checks++;
    if (bus.value !== 14'd8021 || mon_valid !== v0 + 1) begin
      failures++;
      $display("FAIL blank_digit_next: value=%0d valid=%0d, want 8021 %0d", bus.value,
               mon_valid, v0 + 1);
    end
  endtask

  task automatic test_com_err();
    hold(4'b1100, 8'h99, HOLD);
    hold(4'b1111, 8'hFF, 12);
    @(negedge clk);
    checks++;
    if (bus.com_err !== 1'b1) begin
      failures++;
      $display("FAIL com_err_set: com_err=%b, want 1", bus.com_err);
    end
    scan_number(5, 6, 7, 8);
    scan_number(2, 4, 6, 8);
    @(negedge clk);
    checks++;
    if (bus.com_err !== 1'b1 || bus.value !== 14'(exp_value) || mon_err !== exp_err ||
        mon_valid !== exp_valid) begin
      failures++;
      $display("FAIL com_err_sticky: ce=%b value=%0d err=%0d valid=%0d, want 1 %0d %0d %0d",
               bus.com_err, bus.value, mon_err, mon_valid, exp_value, exp_err, exp_valid);
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0;
    hold(4'b1110, {1'b1, pat[8]}, HOLD);
    hold(4'b1101, {1'b1, pat[7]}, HOLD);
    do_reset();
    v0 = mon_valid;
    checks++;
    if (bus.com_err !== 1'b0 || bus.value !== 14'd0) begin
      failures++;
      $display("FAIL reset_clear: ce=%b value=%0d, want 0 0", bus.com_err, bus.value);
    end
    hold(4'b1111, 8'hFF, 12);
    scan_number(4, 3, 2, 1);
    @(negedge clk);
    checks++;
    if (mon_valid !== v0 + 1 || bus.value !== 14'd4321 || bus.digit_bcd !== 16'h4321) begin
      failures++;
      $display("FAIL reset_mid_frame: valid=%0d value=%0d, want %0d 4321", mon_valid,
               bus.value, v0 + 1);
    end
  endtask

  task automatic test_random();
    int rot, slot, dig, ng;
    logic [7:0] d;
    rot = $urandom_range(3);
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < 4; k++) begin
        slot = (k + rot) % 4;
        dig = $urandom_range(9);
        d = {1'($urandom_range(1)), pat[dig]};
        if ($urandom_range(7) == 0) d[6:0] = 7'h7F;
        ng = $urandom_range(3);
        for (int g = 0; g < ng; g++) hold(4'($urandom), 8'($urandom), 1);
        hold(~(4'b0001 << slot), d, HOLD);
      end
    end
    hold(4'b1111, 8'hFF, 12);
    @(negedge clk);
    checks++;
    if (bus.value !== 14'(exp_value) || bus.digit_bcd !== exp_bcd) begin
      failures++;
      $display("FAIL random_value: value=%0d bcd=%h, want %0d %h", bus.value, bus.digit_bcd,
               exp_value, exp_bcd);
    end
    checks++;
    if (mon_valid !== exp_valid || mon_err !== exp_err) begin
      failures++;
      $display("FAIL random_pulses: valid=%0d err=%0d, want %0d %0d", mon_valid, mon_err,
               exp_valid, exp_err);
    end
    checks++;
    if (mon_both !== 0 || mon_max_run !== 1 || bus.com_err !== 1'(m_com_err)) begin
      failures++;
      $display("FAIL random_flags: both=%0d maxrun=%0d ce=%b, want 0 1 %b", mon_both,
               mon_max_run, bus.com_err, m_com_err);
    end
  endtask

  initial begin
    test_reset();
    test_scan_1234();
    test_9999_0000();
    test_glitch();
    test_blank_digit();
    test_com_err();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation still running at %0t, want finished", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fnd_scan_decoder.md
FND_SCAN_DECODER -- requirements
Module: fnd_scan_decoder

Interface
REQ-001 Parameter SETTLE, default 4: consecutive synchronized cycles of unchanged {fnd_com,fnd_data} required before a sample; legal range 2..255.
REQ-002 clk  input  1  single system clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 fnd_com  input  4  digit commons, active-low; bit0 = ones digit ... bit3 = thousands digit.
REQ-005 fnd_data  input  8  segments, active-low; bit7 = dp (ignored), bits6:0 = g,f,e,d,c,b,a.
REQ-006 digit_bcd  output  16  last valid frame, four BCD nibbles, [15:12] = thousands.
REQ-007 value  output  14  binary equivalent of digit_bcd, 0..9999.
REQ-008 frame_valid  output  1  one-cycle pulse when digit_bcd/value update.
REQ-009 frame_err  output  1  one-cycle pulse when a completed frame is discarded.
REQ-010 com_err  output  1  sticky flag: fnd_com seen with more than one bit low; cleared only by reset.

Function
REQ-011 fnd_com and fnd_data SHALL pass through a 2-flop synchronizer; all following rules apply to synchronized values.
REQ-012 A stability counter SHALL clear to 0 on any cycle where the synchronized {com,data} differs from the previous cycle's value, otherwise increment, saturating at SETTLE.
REQ-013 A sample event SHALL occur exactly once per stable period: on the cycle the counter transitions from SETTLE-1 to SETTLE.
REQ-014 At a sample event with com = 1111 (blanking), no state SHALL change.
REQ-015 At a sample event with exactly one com bit low, segments[6:0] SHALL be decoded: 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h, 8=00h, 9=10h.
REQ-016 A valid decode SHALL write the selected digit slot and set its seen bit; re-sampling an already-seen slot overwrites it without error.
REQ-017 A non-matching segment pattern SHALL set an internal frame-error bit and set the slot's seen bit without updating the slot.
REQ-018 At a sample event with two or more com bits low, com_err SHALL set and the frame-error bit SHALL set; no slot changes.
REQ-019 Frame FSM states IDLE (seen = 0000), COLLECT (some seen), COMMIT (all four seen); IDLE->COLLECT on first slot write, COLLECT->COMMIT when seen = 1111.
REQ-020 In COMMIT (one cycle), if frame-error = 0: digit_bcd and value SHALL load from the slots and frame_valid SHALL pulse on the same cycle the new values appear.
REQ-021 In COMMIT, if frame-error = 1: digit_bcd/value SHALL hold, frame_err SHALL pulse.
REQ-022 COMMIT SHALL always return to IDLE, clearing seen and frame-error; a sample event coinciding with COMMIT SHALL be applied to the new frame.
REQ-023 value SHALL equal d3*1000 + d2*100 + d1*10 + d0, computed from the slots without overflow (max 9999 fits 14 bits).
REQ-024 frame_valid and frame_err SHALL never be high in the same cycle.

Reset
REQ-025 While reset = 0, synchronizers, counter, slots, seen, frame-error SHALL clear, FSM = IDLE, all outputs = 0.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; after release, no frame_valid until four new digits are sampled.
REQ-027 First sample after release SHALL require a full SETTLE-cycle stable period measured after the synchronizer fills.

Verification
REQ-028 Scan 1234 (com 1110/data 99h, 1101/B0h, 1011/A4h, 0111/F9h, each held 10 cycles, SETTLE=4) -> one frame_valid, digit_bcd = 1234h, value = 1234.
REQ-029 Scan 9999 then 0000 -> value 9999 then 0; each frame_valid is a single-cycle pulse.
REQ-030 Glitch: data toggles every cycle for 3 cycles then settles -> exactly one sample event per stable period; no spurious slot write.
REQ-031 Digit2 data = FFh (blank pattern) in a frame -> frame_err pulse, digit_bcd holds previous value, next clean frame updates normally.
REQ-032 com = 1100 held 10 cycles -> com_err = 1 and stays 1 through later clean frames until reset.
REQ-033 Reset pulled low after 2 digits of 5678, released, full scan of 4321 -> only one frame_valid, value = 4321.
